// File: rtl/imm_field_encoder.sv
// Immediate field encoder: packs a 64-bit immediate into the 26-bit D/CB/B/I
// instruction field, flags values that the format cannot represent, two-stage valid/ready pipe.
module imm_field_encoder #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 Reset,
  input  logic                 InValid,
  output logic                 InReady,
  input  logic [63:0]          BusImm,
  input  logic [1:0]           Ctrl,
  input  logic [25:0]          InstrIn,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic [25:0]          Imm26,
  output logic                 RangeErr,
  output logic [ERR_CNT_W-1:0] ErrCount
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  // True when the value survives the sign extender round trip for this format.
  function automatic logic in_range(input logic signed [63:0] v, input logic [1:0] c);
    case (c)
      2'b00:   in_range = (v >= -64'sd256)      && (v <= 64'sd255);
      2'b01:   in_range = (v >= -64'sd262144)   && (v <= 64'sd262143);
      2'b10:   in_range = (v >= -64'sd33554432) && (v <= 64'sd33554431);
      default: in_range = (v >= 64'sd0)         && (v <= 64'sd4095);
    endcase
  endfunction

  function automatic logic [25:0] pack(input logic [25:0] instr,
                                       input logic signed [25:0] imm,
                                       input logic [1:0] c);
    logic [25:0] r;
    r = instr;
    case (c)
      2'b00:   r[20:12] = imm[8:0];
      2'b01:   r[23:5]  = imm[18:0];
      2'b10:   r        = imm;
      default: r[21:10] = imm[11:0];
    endcase
    return r;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
    if (&cnt) return cnt;
    return cnt + 1'b1;
  endfunction

  logic signed [63:0] bus_imm_s;
  logic               accept;
  logic               drain;
  logic               s2_load;
  logic               occ_full;
  occ_t               occ_q;
  occ_t               occ_d;

  logic               vld_p1;
  logic [25:0]        instr_p1;
  logic signed [25:0] imm_p1;
  logic [1:0]         ctrl_p1;
  logic               err_p1;

  logic               vld_p2;
  logic [25:0]        imm26_p2;
  logic               err_p2;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign bus_imm_s = BusImm;
  assign s2_load   = vld_p1 & (~vld_p2 | OutReady);
  assign occ_full  = (occ_q == FULL);
  // Ready can ripple straight back from OutReady when both stages are occupied.
  assign InReady   = ~Reset & (~vld_p1 | s2_load) & ~(occ_full & ~OutReady);
  assign accept    = InValid & InReady;
  assign drain     = vld_p2 & OutReady;

  always_ff @(posedge CLK) begin
    if (Reset) occ_q <= EMPTY;
    else       occ_q <= occ_d;
  end

  always_comb begin
    occ_d = occ_q;
    case (occ_q)
      EMPTY:   if (accept) occ_d = ONE;
      ONE: begin
        if (accept && !drain)      occ_d = FULL;
        else if (!accept && drain) occ_d = EMPTY;
      end
      FULL:    if (drain && !accept) occ_d = ONE;
      default: occ_d = EMPTY;
    endcase
  end

  // Stage 1: capture inputs and the range verdict.
  always_ff @(posedge CLK) begin
    if (Reset)        vld_p1 <= 1'b0;
    else if (accept)  vld_p1 <= 1'b1;
    else if (s2_load) vld_p1 <= 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (accept) begin
      instr_p1 <= InstrIn;
      imm_p1   <= bus_imm_s[25:0];
      ctrl_p1  <= Ctrl;
      err_p1   <= ~in_range(bus_imm_s, Ctrl);
    end
  end

  // Stage 2: packed field and error flag drive the outputs directly.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      vld_p2   <= 1'b0;
      imm26_p2 <= '0;
      err_p2   <= 1'b0;
    end else if (s2_load) begin
      vld_p2   <= 1'b1;
      imm26_p2 <= pack(instr_p1, imm_p1, ctrl_p1);
      err_p2   <= err_p1;
    end else if (OutReady) begin
      vld_p2   <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset)                err_cnt_q <= '0;
    else if (drain && err_p2) err_cnt_q <= sat_inc(err_cnt_q);
  end

  assign OutValid = vld_p2;
  assign Imm26    = imm26_p2;
  assign RangeErr = err_p2;
  assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_imm_field_encoder.sv
// Scoreboard bench for imm_field_encoder: stimulus pushes expected words at
// input handshake, a negedge monitor pops and compares at output handshake.
module tb_imm_field_encoder;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        InValid;
  logic        InReady;
  logic [63:0] BusImm;
  logic [1:0]  Ctrl;
  logic [25:0] InstrIn;
  logic        OutValid;
  logic        OutReady;
  logic [25:0] Imm26;
  logic        RangeErr;
  logic [7:0]  ErrCount;

  typedef struct packed {
    logic [25:0] imm;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   exp_cnt = 0;
  int   checks  = 0;
  int   errors  = 0;

  imm_field_encoder #(.ERR_CNT_W(8)) dut (
    .CLK      (CLK),
    .Reset    (Reset),
    .InValid  (InValid),
    .InReady  (InReady),
    .BusImm   (BusImm),
    .Ctrl     (Ctrl),
    .InstrIn  (InstrIn),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .Imm26    (Imm26),
    .RangeErr (RangeErr),
    .ErrCount (ErrCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: handshake at the next rising edge is decided by what is visible now.
  always @(negedge CLK) begin
    if (Reset) begin
      sb.delete();
      exp_cnt = 0;
    end else begin
      chk("errcount", ErrCount, exp_cnt);
      if (OutValid && OutReady) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", Imm26);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("imm26", Imm26, e.imm);
          chk("rangeerr", RangeErr, e.err);
          if (e.err && exp_cnt < 255) exp_cnt++;
        end
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] c, input logic [63:0] imm, input logic [25:0] ins,
                      input logic [25:0] ei, input logic ee);
    bit ok;
    ok = 1'b0;
    InValid = 1'b1;
    Ctrl    = c;
    BusImm  = imm;
    InstrIn = ins;
    for (int k = 0; k < 50; k++) begin
      @(negedge CLK);
      if (InReady) begin
        sb.push_back({ei, ee});
        ok = 1'b1;
        break;
      end
      @(posedge CLK);
      #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=stalled required=accepted");
    end
    @(posedge CLK);
    #1;
    InValid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 100; k++) begin
      if (sb.size() == 0) break;
      @(posedge CLK);
      #1;
    end
    chk("drain_left", sb.size(), 0);
  endtask

  task automatic latency_check(input string nm);
    @(negedge CLK);
    chk({nm, "_early"}, OutValid, 0);
    @(posedge CLK);
    #1;
    @(negedge CLK);
    chk({nm, "_due"}, OutValid, 1);
    @(posedge CLK);
    #1;
  endtask

  initial begin
    InValid  = 1'b0;
    BusImm   = '0;
    Ctrl     = 2'b00;
    InstrIn  = '0;
    OutReady = 1'b1;

    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_outvalid", OutValid, 0);
    chk("rst_imm26", Imm26, 0);
    chk("rst_rangeerr", RangeErr, 0);
    chk("rst_errcount", ErrCount, 0);
    chk("rst_inready", InReady, 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;

    // D type with latency check
    send(2'b00, 64'hFFFF_FFFF_FFFF_FF0F, 26'b00000_000000000_000010000001,
         26'b00000_100001111_000010000001, 1'b0);
    latency_check("lat_d");

    // CB back-to-back pair
    send(2'b01, -64'sd2, 26'b00_0000000000000000000_00010,
         26'b00_1111111111111111110_00010, 1'b0);
    send(2'b01, 64'd2, 26'b00_0000000000000000000_00010,
         26'b00_0000000000000000010_00010, 1'b0);
    // B and I
    send(2'b10, -64'sd119, 26'h0, 26'b11111111111111111110001001, 1'b0);
    send(2'b11, 64'hFF1, 26'b0100_000000000000_0000100000,
         26'b0100_111111110001_0000100000, 1'b0);
    // Pass-through of bits outside the field; B ignores InstrIn
    send(2'b00, 64'd0, 26'h3FFFFFF, 26'h3E00FFF, 1'b0);
    send(2'b10, 64'd5, 26'h3FFFFFF, 26'h0000005, 1'b0);
    send(2'b01, -64'sd262144, 26'h0, 26'h0800000, 1'b0);
    drain();
    @(negedge CLK);
    chk("errcount_clean", ErrCount, 0);
    @(posedge CLK);
    #1;

    // Range errors
    send(2'b11, 64'h1000, 26'h0, 26'h0, 1'b1);
    send(2'b00, 64'd256, 26'h0, 26'h0100000, 1'b1);
    send(2'b10, 64'h200_0000, 26'h0, 26'h2000000, 1'b1);
    drain();
    @(negedge CLK);
    chk("errcount_3", ErrCount, 3);
    @(posedge CLK);
    #1;
    send(2'b01, 64'd262144, 26'h0, 26'h0800000, 1'b1);

    // Saturation
    for (int i = 0; i < 255; i++)
      send(2'b11, 64'hFFFF_0000_0000_0000, 26'h3FFFFFF, 26'h3C003FF, 1'b1);
    drain();
    @(negedge CLK);
    chk("errcount_sat", ErrCount, 255);
    @(posedge CLK);
    #1;

    // Backpressure: two fill the pipe, the third stalls
    OutReady = 1'b0;
    send(2'b11, 64'd1, 26'h0, 26'h0000400, 1'b0);
    send(2'b11, 64'd2, 26'h0, 26'h0000800, 1'b0);
    InValid = 1'b1;
    Ctrl    = 2'b11;
    BusImm  = 64'd3;
    InstrIn = 26'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("bp_inready", InReady, 0);
      chk("bp_outvalid", OutValid, 1);
      chk("bp_hold_imm", Imm26, 26'h0000400);
      chk("bp_hold_err", RangeErr, 0);
      @(posedge CLK);
      #1;
    end
    OutReady = 1'b1;
    send(2'b11, 64'd3, 26'h0, 26'h0000C00, 1'b0);
    drain();

    // Reset with two words in flight
    OutReady = 1'b0;
    send(2'b00, 64'd7, 26'h0, 26'h0007000, 1'b0);
    send(2'b00, 64'd9, 26'h0, 26'h0009000, 1'b0);
    Reset = 1'b1;
    @(negedge CLK);
    chk("mid_rst_inready", InReady, 0);
    @(posedge CLK);
    #1;
    Reset    = 1'b0;
    OutReady = 1'b1;
    @(negedge CLK);
    chk("mid_rst_outvalid", OutValid, 0);
    chk("mid_rst_errcount", ErrCount, 0);
    @(posedge CLK);
    #1;
    send(2'b11, 64'd5, 26'h0, 26'h0001400, 1'b0);
    latency_check("lat_post_rst");
    drain();
    repeat (3) begin
      @(negedge CLK);
      chk("no_stale", OutValid, 0);
      @(posedge CLK);
      #1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_field_encoder.md
Name: imm_field_encoder

Overview:
- Inverse of the datapath sign extender: takes a 64-bit immediate and the 2-bit immediate-type control, and packs it into the 26-bit instruction immediate field used by the D, CB, B and I formats.
- Checks that the value is representable in that format and flags it if not.
- Two-stage valid/ready pipeline; sits in the instruction assembler / self-check path ahead of the instruction memory writer.
- Round-trip property: any word leaving with RangeErr=0, fed back through the sign extender with the same Ctrl, reproduces the original BusImm.

Parameters:
- ERR_CNT_W, 8, width of the saturating range-error counter

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- Reset  input  1  synchronous, active-high reset
- InValid  input  1  upstream presents BusImm/Ctrl/InstrIn
- InReady  output  1  encoder accepts this cycle
- BusImm  input  64  immediate value to encode
- Ctrl  input  2  00=D imm9 signed, 01=CB imm19 signed, 10=B imm26 signed, 11=I imm12 unsigned
- InstrIn  input  26  low 26 instruction bits; non-immediate bits are passed through
- OutValid  output  1  Imm26/RangeErr valid
- OutReady  input  1  downstream accepts this cycle
- Imm26  output  26  InstrIn with the immediate field overwritten
- RangeErr  output  1  BusImm was not representable in the selected format
- ErrCount  output  ERR_CNT_W  count of range-error words delivered downstream, saturating

Behaviour:
- One clock, CLK. Reset is synchronous and active-high, named Reset.
- Reset values: OutValid=0, Imm26=0, RangeErr=0, ErrCount=0, both stage-valid bits=0. While Reset=1, InReady=0. Reset mid-operation discards all in-flight words with no output handshake.
- Field packing, applied to InstrIn; all bits outside the field pass through unchanged:
  - Ctrl 00: Imm26[20:12] = BusImm[8:0].
  - Ctrl 01: Imm26[23:5] = BusImm[18:0].
  - Ctrl 10: Imm26[25:0] = BusImm[25:0]; InstrIn is ignored entirely.
  - Ctrl 11: Imm26[21:10] = BusImm[11:0].
- Range check:
  - Ctrl 00: error unless BusImm[63:8] are all equal to BusImm[8].
  - Ctrl 01: error unless BusImm[63:18] are all equal to BusImm[18].
  - Ctrl 10: error unless BusImm[63:25] are all equal to BusImm[25].
  - Ctrl 11: error unless BusImm[63:12]==0.
  - On error the truncated field is still emitted and RangeErr=1.
- Pipeline:
  - Stage 1 registers the inputs and the range-check result. Stage 2 holds the packed Imm26 and RangeErr, which drive the outputs directly.
  - s2_load = s1_valid & (~s2_valid | OutReady).
  - InReady = ~Reset & (~s1_valid | s2_load). This combinational path from OutReady is intended.
  - Input handshake on InValid&InReady loads stage 1. Output handshake on OutValid&OutReady.
- Occupancy state machine:
  - States EMPTY(0), ONE(1), FULL(2).
  - Accept without drain: +1. Drain without accept: -1. Simultaneous accept and drain: occupancy holds.
  - FULL with OutReady=0 gives InReady=0.
- Latency: a word accepted at edge N shows OutValid=1 after edge N+1 (two-cycle latency) with an empty pipe. Throughput is 1 word/cycle when OutReady is held at 1.
- Output hold: while OutValid=1 and OutReady=0, Imm26 and RangeErr are held stable.
- ErrCount increments by 1 on each output handshake with RangeErr=1. It saturates at 2^ERR_CNT_W-1 and never wraps.

Test Plan:
- D type: Ctrl=00, BusImm=64'hFFFF_FFFF_FFFF_FF0F, InstrIn=26'b00000_000000000_000010000001, OutReady=1 -> two cycles after accept, Imm26=26'b00000_100001111_000010000001, RangeErr=0.
- CB type: Ctrl=01, BusImm=-2, InstrIn=26'b00_0000000000000000000_00010 -> Imm26=26'b00_1111111111111111110_00010. Then BusImm=2 -> Imm26=26'b00_0000000000000000010_00010. Back-to-back words, one per cycle, in order.
- B and I types: Ctrl=10, BusImm=-119 -> Imm26=26'b11111111111111111110001001. Ctrl=11, BusImm=12'hFF1, InstrIn=26'b0100_000000000000_0000100000 -> Imm26=26'b0100_111111110001_0000100000. RangeErr=0 for both.
- Range errors: Ctrl=11, BusImm=64'h1000 -> RangeErr=1, field=0, ErrCount=1. Ctrl=00, BusImm=256 -> RangeErr=1, ErrCount=2. Ctrl=10, BusImm=2^25 -> RangeErr=1, ErrCount=3. Preload the counter near max and confirm it saturates at 255.
- Backpressure: OutReady=0, offer 3 words -> 2 accepted, InReady=0 on the third, outputs held stable. Raise OutReady -> all 3 words emerge in order, no loss or duplication.
- Reset mid-stream: two words in flight, Reset=1 for 1 cycle -> OutValid=0, ErrCount=0, no stale word emitted. The next word has two-cycle latency.
